// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a load-use scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic                     Wr0En,
  input  logic [ADDR_W-1:0]        Wr0Addr,
  input  logic [DATA_W-1:0]        Wr0Data,
  input  logic                     Wr1En,
  input  logic [ADDR_W-1:0]        Wr1Addr,
  input  logic [DATA_W-1:0]        Wr1Data,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueAddr,
  output logic [ADDR_W:0]          BusyCnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              issueHit;
  logic              wr1Hit;
  logic              setEv;
  logic              clrEv;

  assign issueHit = IssueEn && (IssueAddr != '0);
  assign wr1Hit   = Wr1En && (Wr1Addr != '0);

  // Count only real bit transitions so BusyCnt tracks popcount(busy).
  assign setEv = issueHit && !busy[IssueAddr];
  assign clrEv = wr1Hit && busy[Wr1Addr]
              && !(issueHit && (IssueAddr == Wr1Addr));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (Wr1En && (Wr1Addr == ADDR_W'(i)))
          mem[i] <= Wr1Data;
        else if (Wr0En && (Wr0Addr == ADDR_W'(i)))
          mem[i] <= Wr0Data;
      end
    end
  end

  // Issue is applied after the clear so a new load wins the collision.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy <= '0;
    end else begin
      if (wr1Hit) busy[Wr1Addr] <= 1'b0;
      if (issueHit) busy[IssueAddr] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BusyCnt <= '0;
    end else if (setEv && !clrEv) begin
      BusyCnt <= BusyCnt + CNT_ONE;
    end else if (clrEv && !setEv) begin
      BusyCnt <= BusyCnt - CNT_ONE;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    assign a = RdAddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (Wr0En && (Wr0Addr == a)) d = Wr0Data;
      if (Wr1En && (Wr1Addr == a)) d = Wr1Data;
`endif
      if (!RST || (a == '0)) d = '0;
    end

    assign RdData[k*DATA_W +: DATA_W] = d;
    assign RdBusy[k] = RST && busy[a];
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth = 2^ADDR_W, entry 0 hardwired zero.
REQ-003 SHALL provide parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port RdAddr  input  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port RdData  output  NUM_RD*DATA_W  packed read data, combinational.
REQ-008 SHALL have port RdBusy  output  NUM_RD  per-port scoreboard busy flag of addressed register.
REQ-009 SHALL have ports Wr0En, Wr0Addr, Wr0Data  input  1/ADDR_W/DATA_W  ALU write port.
REQ-010 SHALL have ports Wr1En, Wr1Addr, Wr1Data  input  1/ADDR_W/DATA_W  load writeback port; clears busy.
REQ-011 SHALL have ports IssueEn, IssueAddr  input  1/ADDR_W  mark destination register busy (load issued).
REQ-012 SHALL have port BusyCnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-013 Reads SHALL be combinational; address 0 SHALL return 0 and RdBusy=0 regardless of writes.
REQ-014 Writes SHALL occur on rising CLK when enable=1 and address!=0; writes to address 0 SHALL be discarded.
REQ-015 When Wr0 and Wr1 target the same nonzero address in one cycle, Wr1Data SHALL be stored.
REQ-016 Scoreboard: busy[a] SHALL set on rising CLK when IssueEn=1 and IssueAddr=a!=0.
REQ-017 busy[a] SHALL clear on rising CLK when Wr1En=1 and Wr1Addr=a; Wr0 SHALL NOT affect busy.
REQ-018 Simultaneous issue and Wr1 clear to the same address SHALL leave busy set (new load wins); data still written.
REQ-019 Issue to an already-busy register SHALL keep it busy, BusyCnt unchanged.
REQ-020 Wr1 to a non-busy register SHALL write data, BusyCnt unchanged (no underflow).
REQ-021 BusyCnt SHALL be a registered counter updated the same edge as busy bits: +1 on set-only, -1 on clear-only, else hold; SHALL always equal popcount(busy).
REQ-022 RdBusy[k] SHALL reflect registered busy state (no forwarding of same-cycle issue or clear).
REQ-023 Maximum BusyCnt SHALL be 2^ADDR_W-1; counter SHALL not wrap.

Reset
REQ-024 RST=0 SHALL asynchronously clear all entries to 0, all busy bits to 0, BusyCnt to 0.
REQ-025 Reset mid-operation SHALL drop pending writes and issues of that cycle; RdData SHALL read 0 and RdBusy 0 while RST=0.
REQ-026 Simulation initial state SHALL equal reset state.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined, RdData[k] SHALL return the same-cycle write data when an enabled write targets RdAddr[k]!=0 (Wr1 over Wr0 on collision), zero latency.
REQ-029 Without REGFILE_BYPASS_EN, RdData[k] SHALL return stored value only; written data visible the cycle after the edge.

Verification
REQ-030 Reset then read all addresses on both ports -> RdData=0, RdBusy=0, BusyCnt=0.
REQ-031 Wr0En=1, Wr0Addr=0, Wr0Data=0xDEADBEEF; next cycle read addr 0 -> 0x00000000.
REQ-032 Same cycle Wr0 (addr 5, 0x11111111) and Wr1 (addr 5, 0x22222222); next cycle read addr 5 -> 0x22222222; with bypass, same-cycle read -> 0x22222222, without -> old value 0.
REQ-033 Issue addr 7, addr 9 on consecutive cycles -> BusyCnt 1 then 2, RdBusy=1 reading 7; Wr1 addr 7 -> BusyCnt 1, RdBusy(7)=0.
REQ-034 IssueEn addr 3 and Wr1 addr 3 same cycle with busy[3]=1 -> busy[3]=1, BusyCnt unchanged, data written; Wr1 addr 4 when not busy -> BusyCnt unchanged.
REQ-035 Fill regs 1..31 with 0xA5A5A5A5, issue 31 regs -> BusyCnt=31; assert RST=0 mid-cycle -> immediate RdData=0, BusyCnt=0.
